// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
//   General-purpose register file placed right after the write-back stage.
//   There is one write port (we/waddr/wdata, fed by wb_wreg/wb_wd/wb_wdata)
//   and two read ports for decode. A write-through bypass makes a write in
//   the current cycle visible to both readers in that same cycle.
//   Register 0 is hardwired to zero.
//
//   Optional feature, enabled by defining the macro REGFILE_PARITY_EN:
//     Each register gets an even-parity bit. The input par_inject corrupts
//     that bit on write. The output par_err is a sticky error flag that
//     only reset clears.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous reset, active-low (0 = reset)
//   we        in   1       write enable
//   waddr     in   ADDR_W  write address
//   wdata     in   DATA_W  write data
//   re1/re2   in   1       read enables
//   raddr1/2  in   ADDR_W  read addresses
//   rdata1/2  out  DATA_W  combinational read data
//   wr_count  out  16      committed-write counter (wraps)
//   par_inject in  1       (REGFILE_PARITY_EN) invert stored parity on write
//   par_err    out 1       (REGFILE_PARITY_EN) sticky parity-error flag
// -----------------------------------------------------------------------------
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [15:0]       wr_count
`ifdef REGFILE_PARITY_EN
  ,
  input  logic              par_inject,
  output logic              par_err
`endif
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;
  logic              commit;

  // Writes to r0 are dropped entirely, so they are not counted either.
  assign commit     = we && (waddr != '0);
  assign wr_count_d = wr_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else if (commit) begin
      regs_q[waddr] <= wdata;
      wr_count_q    <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

  // Read priority: reset, enable, r0, same-cycle write bypass, storage.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic              rst_n_v,
    input logic              ren,
    input logic [ADDR_W-1:0] ra,
    input logic              we_v,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    r = '0;
    if (rst_n_v && ren && (ra != '0)) begin
      if (we_v && (wa == ra)) r = wd;
      else                    r = stored;
    end
    return r;
  endfunction

  always_comb begin
    rdata1 = rd_sel(rst, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
    rdata2 = rd_sel(rst, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
  end

`ifdef REGFILE_PARITY_EN
  logic par_q [NUM_REGS];
  logic par_err_q;
  logic par_err_d;
  logic chk1;
  logic chk2;
  logic bad1;
  logic bad2;

  // A bypassed read never touches storage, so it is not checked.
  assign chk1 = re1 && (raddr1 != '0) && !(we && (waddr == raddr1));
  assign chk2 = re2 && (raddr2 != '0) && !(we && (waddr == raddr2));
  assign bad1 = chk1 && ((^regs_q[raddr1]) != par_q[raddr1]);
  assign bad2 = chk2 && ((^regs_q[raddr2]) != par_q[raddr2]);
  assign par_err_d = par_err_q || bad1 || bad2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) par_q[i] <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (commit) par_q[waddr] <= (^wdata) ^ par_inject;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule
